// File: rtl/sat_sub_accum_pkg.sv
// Shared types and clamp-limit helpers for the saturating subtract accumulator.
package sat_sub_accum_pkg;

    // Operation sequencing: wait for start, consume subtrahends, present result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Largest value representable in a w-bit two's-complement word.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Smallest value representable in a w-bit two's-complement word.
    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/sat_subtractor.sv
// Combinational a - b, computed one bit wider than the operands and clamped
// back into the operand range; sat reports that clamping happened.
module sat_subtractor
    import sat_sub_accum_pkg::*;
#(
    parameter int width = 10
) (
    input  logic signed [width-1:0] a,
    input  logic signed [width-1:0] b,
    output logic signed [width-1:0] d,
    output logic                    sat
);

    localparam logic signed [width:0] hi = (width + 1)'(sat_max(width));
    localparam logic signed [width:0] lo = (width + 1)'(sat_min(width));

    logic signed [width:0] diff;

    // Sign-extend, subtract at full precision, then clamp to the word range.
    always_comb begin
        diff = {a[width-1], a} - {b[width-1], b};
        d    = diff[width-1:0];
        sat  = 1'b0;
        if (diff > hi) begin
            d   = hi[width-1:0];
            sat = 1'b1;
        end else if (diff < lo) begin
            d   = lo[width-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/sat_sub_accum.sv
// Saturating subtract accumulator: loads a minuend on start, subtracts
// n_terms handshaken subtrahends with clamping, then holds the result
// until the consumer takes it.
module sat_sub_accum
    import sat_sub_accum_pkg::*;
#(
    parameter int width   = 10,
    parameter int n_terms = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [width-1:0] init,
    input  logic                    in_valid,
    input  logic signed [width-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic signed [width-1:0] out_data,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    sat_flag
);

    localparam int cw = $clog2(n_terms + 1);
    localparam logic [cw-1:0] last = cw'(n_terms - 1);

    state_t                    state;
    logic signed [width-1:0]   acc;
    logic        [cw-1:0]      cnt;
    logic signed [width-1:0]   diff;
    logic                      diffSat;

    sat_subtractor #(
        .width(width)
    ) u_sub (
        .a  (acc),
        .b  (in_data),
        .d  (diff),
        .sat(diffSat)
    );

    // Sequencing FSM with all handshake/status outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sat_flag  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= init;
                        cnt      <= '0;
                        sat_flag <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc <= diff;
                        cnt <= cnt + cw'(1);
                        if (diffSat) begin
                            sat_flag <= 1'b1;
                        end
                        if (cnt == last) begin
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= diff;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sat_sub_accum.md
SAT_SUB_ACCUM -- requirements
Module: sat_sub_accum

Interface
REQ-001 SHALL have parameter width, default 10: two's-complement data width.
REQ-002 SHALL have parameter n_terms, default 4: subtrahends consumed per operation, legal range >= 1.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin an operation; sampled only in IDLE.
REQ-006 SHALL have port init  input  width  signed minuend, loaded when start is accepted.
REQ-007 SHALL have port in_valid  input  1  subtrahend present on in_data.
REQ-008 SHALL have port in_data  input  width  signed subtrahend.
REQ-009 SHALL have port in_ready  output  1  block accepts a subtrahend this cycle.
REQ-010 SHALL have port out_valid  output  1  final result present on out_data.
REQ-011 SHALL have port out_data  output  width  signed saturated result.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port sat_flag  output  1  sticky: at least one step of the current operation saturated.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-016 IDLE: start=1 SHALL load acc<=init, cnt<=0, sat_flag<=0 and go to ACCUM the next cycle.
REQ-017 ACCUM: in_ready SHALL be 1; all other states SHALL drive in_ready=0.
REQ-018 Accept (in_valid & in_ready) SHALL set acc<=sat(acc - in_data), cnt<=cnt+1; no accept SHALL leave acc and cnt unchanged.
REQ-019 The accept that brings cnt to n_terms SHALL move to HOLD; out_valid SHALL be 1 the cycle after that accept (latency 1).
REQ-020 HOLD: out_valid=1, out_data=acc; out_data and sat_flag SHALL stay stable while out_ready=0.
REQ-021 HOLD with out_ready=1 SHALL return to IDLE; out_valid SHALL be 0 the next cycle.
REQ-022 start SHALL be ignored in ACCUM and HOLD; start in the same cycle as the HOLD handshake SHALL be ignored (at least one IDLE cycle between operations).
REQ-023 Subtraction SHALL be computed at width+1 bits and clamped to [-2^(width-1), 2^(width-1)-1].
REQ-024 Clamping SHALL set sat_flag<=1 in the same cycle; later steps SHALL continue from the clamped value.
REQ-025 out_data SHALL reflect acc only in HOLD and SHALL be 0 in IDLE and ACCUM.
REQ-026 cnt SHALL be $clog2(n_terms+1) bits wide; it SHALL never wrap within an operation.

Reset
REQ-027 reset=1 SHALL, at the next clock edge and in any state (including mid-ACCUM), force IDLE with acc=0, cnt=0, in_ready=0, out_valid=0, out_data=0, busy=0 and sat_flag=0.
REQ-028 reset SHALL take priority over start, in_valid and out_ready in the same cycle.

Structure
REQ-029 The state enum typedef SHALL be defined in the shared package.
REQ-030 The clamp limits derived from width SHALL be defined in the shared package.
REQ-031 The combinational saturating subtract SHALL be a sub-module sat_subtractor (a, b, d, sat) instantiated once.

Verification (width=10, n_terms=4)
REQ-032 init=100; subtrahends 10,20,30,40 back-to-back -> out_valid one cycle after 4th accept; out_data=0; sat_flag=0.
REQ-033 init=511; subtrahends -256,-256,0,0 -> out_data=511 (0111111111); sat_flag=1.
REQ-034 init=-512; subtrahends 1,1,-1,0 -> acc steps -512,-512,-511,-511; out_data=-511; sat_flag=1.
REQ-035 Subtrahends 5,5,5,5 with in_valid low on alternate cycles, init=0 -> only accepted beats counted; out_data=-20.
REQ-036 out_ready held 0 for 5 cycles in HOLD, start pulsed meanwhile -> out_valid/out_data stable, in_ready=0, start ignored; out_ready=1 -> IDLE next cycle.
REQ-037 reset after 2 accepts -> next cycle all outputs 0, state IDLE; new operation init=7, subtrahends 1,1,1,1 -> out_data=3.
